// File: rtl/video_pkg.sv
// video_pkg: shared state encoding, default raster timing and pixel width for the video stream transmitter.
package video_pkg;

    localparam int PIX_W          = 24;
    localparam int DEF_PIC_WIDTH  = 640;
    localparam int DEF_PIC_HEIGHT = 480;
    localparam int DEF_H_BLANK    = 16;
    localparam int DEF_V_PRE      = 4;
    localparam int DEF_V_POST     = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VPRE   = 3'd1,
        ACTIVE = 3'd2,
        HBLANK = 3'd3,
        VPOST  = 3'd4
    } state_t;

    // a count of 1 still needs a 1-bit register
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/video_stream_tx.sv
// video_stream_tx: turns a valid/ready RGB888 pixel source into a registered vsync/href/clken raster stream.
module video_stream_tx
    import video_pkg::*;
#(
    parameter int PIC_WIDTH  = DEF_PIC_WIDTH,
    parameter int PIC_HEIGHT = DEF_PIC_HEIGHT,
    parameter int H_BLANK    = DEF_H_BLANK,
    parameter int V_PRE      = DEF_V_PRE,
    parameter int V_POST     = DEF_V_POST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             src_valid,
    input  logic [PIX_W-1:0] src_data,
    output logic             src_ready,
    output logic             post_frame_vsync,
    output logic             post_frame_href,
    output logic             post_frame_clken,
    output logic [PIX_W-1:0] post_img,
    output logic             busy,
    output logic             frame_done,
    output logic             underflow
);

    localparam int TMAX = (V_PRE > H_BLANK) ? ((V_PRE > V_POST) ? V_PRE : V_POST)
                                            : ((H_BLANK > V_POST) ? H_BLANK : V_POST);
    localparam int CW = cnt_w(PIC_WIDTH);
    localparam int RW = cnt_w(PIC_HEIGHT);
    localparam int TW = cnt_w(TMAX);

    localparam logic [CW-1:0] COL_LAST = CW'(PIC_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PIC_HEIGHT - 1);
    localparam logic [TW-1:0] T_PRE    = TW'(V_PRE - 1);
    localparam logic [TW-1:0] T_HB     = TW'(H_BLANK - 1);
    localparam logic [TW-1:0] T_POST   = TW'(V_POST - 1);

    state_t        state, nxt;
    logic [CW-1:0] col, col_n;
    logic [RW-1:0] row, row_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          accept;

    assign src_ready = rst_n && (state == ACTIVE);
    assign accept    = src_valid && src_ready;
    assign busy      = post_frame_vsync;

    always_comb begin
        nxt    = state;
        col_n  = col;
        row_n  = row;
        tcnt_n = tcnt;
        case (state)
            IDLE: begin
                nxt    = start ? VPRE : IDLE;
                tcnt_n = '0;
            end
            VPRE: begin
                nxt    = (tcnt == T_PRE) ? ACTIVE : VPRE;
                tcnt_n = (tcnt == T_PRE) ? '0 : tcnt + 1'b1;
                row_n  = '0;
                col_n  = '0;
            end
            ACTIVE: begin
                if (accept) begin
                    nxt   = (col != COL_LAST) ? ACTIVE : (row == ROW_LAST) ? VPOST : HBLANK;
                    col_n = (col == COL_LAST) ? '0 : col + 1'b1;
                end
                tcnt_n = '0;
            end
            HBLANK: begin
                nxt    = (tcnt == T_HB) ? ACTIVE : HBLANK;
                tcnt_n = (tcnt == T_HB) ? '0 : tcnt + 1'b1;
                row_n  = (tcnt == T_HB) ? row + 1'b1 : row;
            end
            VPOST: begin
                nxt    = (tcnt == T_POST) ? IDLE : VPOST;
                tcnt_n = (tcnt == T_POST) ? '0 : tcnt + 1'b1;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            col              <= '0;
            row              <= '0;
            tcnt             <= '0;
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img         <= '0;
            frame_done       <= 1'b0;
            underflow        <= 1'b0;
        end else begin
            state            <= nxt;
            col              <= col_n;
            row              <= row_n;
            tcnt             <= tcnt_n;
            post_frame_vsync <= (nxt != IDLE);
            // href covers every ACTIVE cycle one clock late so it brackets the delayed clken exactly
            post_frame_href  <= ((state == ACTIVE) && (nxt == ACTIVE)) || accept;
            post_frame_clken <= accept;
            post_img         <= accept ? src_data : post_img;
            frame_done       <= (state == VPOST) && (nxt == IDLE);
            underflow        <= ((state == IDLE) && start) ? 1'b0
                              : ((state == ACTIVE) && !src_valid) ? 1'b1 : underflow;
        end
    end

endmodule

// File: tb/tb_video_stream_tx.sv
// tb_video_stream_tx: random and directed frames checked cycle by cycle against a timeline model of the raster.
module tb_video_stream_tx;

    localparam int W = 4, H = 2, HB = 2, VP = 2, VQ = 2, N = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        src_valid = 1'b0;
    logic [23:0] src_data = '0;
    logic        src_ready, vsync, href, clken, busy, frame_done, underflow;
    logic [23:0] post_img;

    video_stream_tx #(
        .PIC_WIDTH (W),
        .PIC_HEIGHT(H),
        .H_BLANK   (HB),
        .V_PRE     (VP),
        .V_POST    (VQ)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .src_valid       (src_valid),
        .src_data        (src_data),
        .src_ready       (src_ready),
        .post_frame_vsync(vsync),
        .post_frame_href (href),
        .post_frame_clken(clken),
        .post_img        (post_img),
        .busy            (busy),
        .frame_done      (frame_done),
        .underflow       (underflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0, frame_no = 0;

    bit          v[N];
    logic [23:0] d[N];
    bit          e_vs[N], e_hr[N], e_ck[N], e_rdy[N], e_fd[N], e_uf[N], stall[N];
    logic [23:0] e_img[N];
    int          flen;
    bit          uf_model = 1'b0;
    logic [23:0] img_model = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // frame as a timeline: V_PRE cycles, each line consumes cycles until W valid pixels, H_BLANK between lines, V_POST tail
    task automatic build_model();
        int t, acc;
        bit u;
        logic [23:0] cur;
        for (int i = 0; i < N; i++) begin
            e_vs[i] = 0; e_hr[i] = 0; e_ck[i] = 0; e_rdy[i] = 0; e_fd[i] = 0; stall[i] = 0;
        end
        t = VP;
        for (int r = 0; r < H; r++) begin
            acc = 0;
            while (acc < W) begin
                e_rdy[t] = 1;
                e_hr[t+1] = 1;
                if (v[t]) begin
                    acc++;
                    e_ck[t+1] = 1;
                end else stall[t] = 1;
                t++;
            end
            if (r < H - 1) t += HB;
        end
        t += VQ;
        flen = t;
        for (int k = 0; k < flen; k++) e_vs[k] = 1;
        e_fd[flen] = 1;
        u = 0;
        cur = img_model;
        for (int k = 0; k <= flen; k++) begin
            if (k > 0) begin
                u = u | stall[k-1];
                if (e_ck[k]) cur = d[k-1];
            end
            e_uf[k] = u;
            e_img[k] = cur;
        end
    endtask

    task automatic run_frame(input int mode, input bit pre_started, input bit b2b,
                             input int busy_start_at, input int exp_len);
        int vs_cnt, fd_cnt;
        string p;
        for (int i = 0; i < N; i++) begin
            d[i] = 24'($urandom);
            case (mode)
                0: v[i] = 1;
                1: v[i] = !(i >= VP + 2 && i < VP + 5);
                default: v[i] = (i >= 60) || ($urandom_range(3) != 0);
            endcase
        end
        build_model();
        frame_no++;
        if (!pre_started) start = 1;
        @(posedge clk);
        #1 start = 0;
        vs_cnt = 0;
        fd_cnt = 0;
        for (int k = 0; k <= flen; k++) begin
            src_valid = (k < flen) ? v[k] : 1'b0;
            src_data  = d[k];
            start     = (k == busy_start_at) || (b2b && k == flen);
            @(negedge clk);
            p = $sformatf("f%0d c%0d", frame_no, k);
            check({p, " vsync"}, vsync, e_vs[k]);
            check({p, " href"}, href, e_hr[k]);
            check({p, " clken"}, clken, e_ck[k]);
            check({p, " ready"}, src_ready, e_rdy[k]);
            check({p, " done"}, frame_done, e_fd[k]);
            check({p, " underflow"}, underflow, e_uf[k]);
            check({p, " busy"}, busy, e_vs[k]);
            check({p, " img"}, post_img, e_img[k]);
            vs_cnt += int'(vsync);
            fd_cnt += int'(frame_done);
            if (k < flen) begin
                @(posedge clk);
                #1;
            end
        end
        check($sformatf("f%0d vsync_len", frame_no), vs_cnt, (exp_len < 0) ? flen : exp_len);
        check($sformatf("f%0d done_count", frame_no), fd_cnt, 1);
        uf_model  = e_uf[flen];
        img_model = e_img[flen];
    endtask

    task automatic idle(input int n);
        src_valid = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            check($sformatf("idle%0d vsync", i), vsync, 0);
            check($sformatf("idle%0d done", i), frame_done, 0);
            check($sformatf("idle%0d underflow", i), underflow, uf_model);
            check($sformatf("idle%0d img", i), post_img, img_model);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset outs", {vsync, href, clken, frame_done, underflow, busy}, 0);
        check("reset img", post_img, 0);
        check("reset ready", src_ready, 0);
        @(posedge clk);
        #1 rst_n = 1;
        idle(2);

        run_frame(0, 0, 0, -1, 14);
        idle(3);
        run_frame(1, 0, 0, -1, 17);
        idle(2);
        run_frame(0, 0, 0, 6, 14);
        idle(2);
        run_frame(1, 0, 1, -1, 17);
        run_frame(0, 1, 0, -1, 14);
        idle(2);

        // abort during line 1, then a full fresh frame
        start = 1;
        @(posedge clk);
        #1 start = 0;
        src_valid = 1;
        for (int k = 0; k < 9; k++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 0;
        @(negedge clk);
        check("midrst ready", src_ready, 0);
        @(posedge clk);
        #1 rst_n = 1;
        src_valid = 0;
        @(negedge clk);
        check("midrst outs", {vsync, href, clken, frame_done, underflow, busy}, 0);
        check("midrst img", post_img, 0);
        uf_model  = 0;
        img_model = '0;
        idle(4);
        run_frame(0, 0, 0, -1, 14);
        idle(2);

        for (int i = 0; i < 6; i++) begin
            run_frame(2, 0, 0, -1, -1);
            idle(2);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
